// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and address type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_pkg;

  localparam int        NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Conventional ABI register numbers.
  localparam logic [4:0] REG_GP = 5'd28;
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_RA = 5'd31;

  typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/Register_posedge.sv
// Enabled register cell: captures i_d on a rising edge when i_en is high.
// Latency: 1 cycle from i_d/i_en to o_q.
// Backpressure: none; i_en low simply holds the stored value.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low clear
//   i_en   load enable
//   i_d    data to load
//   o_q    stored value
module Register_posedge #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_file_2r1w.sv
// 32 x N MIPS GPR file: one write port, two registered read ports with write bypass.
// Latency: reads 1 cycle; a same-cycle write to the read address is forwarded.
// Backpressure: read_enable=0 holds both read outputs and drops read_valid; writes continue.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low clear of all entries and outputs
//   reg_write    write strobe (WB stage)
//   write_addr   destination register
//   write_data   data written on the next rising edge
//   read_enable  0 = stall, read outputs hold
//   read_addr1   rs address
//   read_addr2   rt address
//   read_data1   registered rs value
//   read_data2   registered rt value
//   read_valid   read_data1/2 were loaded on the previous rising edge
module register_file_2r1w
  import mips_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [N-1:0]      write_data,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [N-1:0]      read_data1,
  output logic [N-1:0]      read_data2,
  output logic              read_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Write qualifier: a write to register zero is dropped everywhere,
  // including the bypass compare below.
  logic w_wr_live;
  assign w_wr_live = reg_write && (write_addr != ADDR_W'(REG_ZERO));

  logic [N-1:0] w_entry [DEPTH];
  logic         w_wr_en [DEPTH];

  // Entry 0 is a constant; it has no storage cell.
  assign w_entry[0] = '0;
  assign w_wr_en[0] = 1'b0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_entry
    // One-hot decode of the write address gated by the strobe.
    assign w_wr_en[g] = reg_write && (write_addr == ADDR_W'(g));

    Register_posedge #(
      .W (N)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_wr_en[g]),
      .i_d   (write_data),
      .o_q   (w_entry[g])
    );
  end

  // Read muxes with write-to-read bypass. Forwarding the incoming write
  // keeps the ID stage from seeing a stale value when WB targets rs/rt
  // in the same cycle.
  logic         w_byp1;
  logic         w_byp2;
  logic [N-1:0] w_rd1;
  logic [N-1:0] w_rd2;

  assign w_byp1 = w_wr_live && (write_addr == read_addr1);
  assign w_byp2 = w_wr_live && (write_addr == read_addr2);
  assign w_rd1  = w_byp1 ? write_data : w_entry[read_addr1];
  assign w_rd2  = w_byp2 ? write_data : w_entry[read_addr2];

  logic [N-1:0] r_read_data1;
  logic [N-1:0] r_read_data2;
  logic         r_read_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data1 <= '0;
      r_read_data2 <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= read_enable;
      // During a stall the outputs keep what they captured last, even if
      // the underlying entry is rewritten meanwhile.
      if (read_enable) begin
        r_read_data1 <= w_rd1;
        r_read_data2 <= w_rd2;
      end
    end
  end

  assign read_data1 = r_read_data1;
  assign read_data2 = r_read_data2;
  assign read_valid = r_read_valid;

endmodule
